// File: rtl/rv_rr_arbiter.sv
// Round-robin merge of N_REQ ready/valid streams onto one registered channel.
// Optional burst lock keeps a requester granted for up to BURST_MAX beats.
module rv_rr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int N_REQ     = 4,
    parameter int BURST_MAX = 1,
    parameter int SRC_W     = $clog2(N_REQ)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ*WIDTH-1:0] i_dat,
    input  logic [N_REQ-1:0]       i_valid,
    output logic [N_REQ-1:0]       i_ready,
    output logic [WIDTH-1:0]       o_dat,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [SRC_W-1:0]       o_src
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);

    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic             vld_q, vld_d;

    logic             load;
    logic             stay;
    logic             found;
    logic             sel_valid;
    logic [SRC_W-1:0] sel;
    logic             xfer;
    int               idx;

    assign load = !vld_q || o_ready;

    // burst_q == 0 only after reset: no owner yet, so the search decides
    assign stay = (burst_q != '0) && (burst_q < BMAX) && i_valid[ptr_q];

    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        idx   = 0;
        if (stay) begin
            found = 1'b1;
        end else begin
            for (int i = 1; i <= N_REQ; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
                if (!found && i_valid[idx]) begin
                    found = 1'b1;
                    sel   = SRC_W'(idx);
                end
            end
        end
    end

    assign sel_valid = found;
    assign xfer      = !reset && load && sel_valid;

    always_comb begin
        i_ready = '0;
        if (xfer) begin
            i_ready = N_REQ'(1) << sel;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        burst_d = burst_q;
        dat_d   = dat_q;
        src_d   = src_q;
        vld_d   = vld_q;
        if (xfer) begin
            dat_d = i_dat[sel*WIDTH +: WIDTH];
            src_d = sel;
            vld_d = 1'b1;
            ptr_d = sel;
            if (sel == ptr_q) begin
                if (burst_q != BMAX) begin
                    burst_d = burst_q + BW'(1);
                end
            end else begin
                burst_d = BW'(1);
            end
        end else if (vld_q && o_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q   <= SRC_W'(N_REQ - 1);
            burst_q <= '0;
            dat_q   <= '0;
            src_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            dat_q   <= dat_d;
            src_q   <= src_d;
            vld_q   <= vld_d;
        end
    end

    assign o_dat   = dat_q;
    assign o_src   = src_q;
    assign o_valid = vld_q;

endmodule
